// File: rtl/rob_multi_pkg.sv
// Shared types and default sizing for the multi-retire reorder buffer.
package rob_multi_pkg;

    localparam int unsigned ROB_N_ENTRIES    = 16;
    localparam int unsigned ROB_N_WB_PORTS   = 3;
    localparam int unsigned ROB_RETIRE_WIDTH = 2;
    localparam int unsigned ROB_N_RD_PORTS   = 2;
    localparam int unsigned ARF_ID_W         = 5;
    localparam int unsigned XLEN             = 32;

    typedef logic [$clog2(ROB_N_ENTRIES)-1:0] rob_id_t;

    typedef struct packed {
        logic                dst_valid;
        logic [ARF_ID_W-1:0] dst_arf_id;
        logic [XLEN-1:0]     pc;
    } rob_dispatch_data_t;

    typedef struct packed {
        logic                valid;
        logic                dst_valid;
        logic [ARF_ID_W-1:0] dst_arf_id;
        logic [XLEN-1:0]     pc_npc;
        logic                br_mispred;
        logic                is_executed;
        logic [XLEN-1:0]     reg_data;
    } rob_entry_t;

    // Width needed to hold a retire count in 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Prefix-AND over the head window: a slot retires only if every older slot retires
// and no older retiring slot was a mispredicted branch.
module rob_retire_select
    import rob_multi_pkg::*;
#(
    parameter int unsigned RETIRE_WIDTH = ROB_RETIRE_WIDTH,
    parameter int unsigned CNT_W        = cnt_width(ROB_RETIRE_WIDTH)
) (
    input  logic [RETIRE_WIDTH-1:0] valid_i,
    input  logic [RETIRE_WIDTH-1:0] executed_i,
    input  logic [RETIRE_WIDTH-1:0] mispred_i,
    output logic [RETIRE_WIDTH-1:0] retire_o,
    output logic [CNT_W-1:0]        retire_cnt_o,
    output logic                    flush_o
);

    logic chain;

    always_comb begin
        retire_o     = '0;
        retire_cnt_o = '0;
        flush_o      = 1'b0;
        chain        = 1'b1;
        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            if (chain && valid_i[k] && executed_i[k]) begin
                retire_o[k]  = 1'b1;
                retire_cnt_o = retire_cnt_o + CNT_W'(1);
                // A mispredicted branch retires but closes the window behind it.
                if (mispred_i[k]) begin
                    flush_o = 1'b1;
                    chain   = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer: single dispatch, N writeback ports, up to RETIRE_WIDTH in-order
// retires per cycle, flush on retiring mispredict, operand reads with writeback bypass.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int unsigned N_ENTRIES    = ROB_N_ENTRIES,
    parameter int unsigned N_WB_PORTS   = ROB_N_WB_PORTS,
    parameter int unsigned RETIRE_WIDTH = ROB_RETIRE_WIDTH,
    parameter int unsigned N_RD_PORTS   = ROB_N_RD_PORTS,
    parameter int unsigned ID_W         = $clog2(N_ENTRIES)
) (
    input  logic                                 clk,
    input  logic                                 rst_aL,

    input  logic                                 dispatch_valid,
    output logic                                 dispatch_ready,
    output logic [ID_W-1:0]                      dispatch_rob_id,
    input  rob_dispatch_data_t                   dispatch_data,

    input  logic [N_RD_PORTS-1:0][ID_W-1:0]      rd_rob_id,
    output logic [N_RD_PORTS-1:0]                rd_ready,
    output logic [N_RD_PORTS-1:0][XLEN-1:0]      rd_data,

    input  logic [N_WB_PORTS-1:0]                wb_valid,
    input  logic [N_WB_PORTS-1:0][ID_W-1:0]      wb_rob_id,
    input  logic [N_WB_PORTS-1:0][XLEN-1:0]      wb_reg_data,
    input  logic [N_WB_PORTS-1:0]                wb_npc_valid,
    input  logic [N_WB_PORTS-1:0]                wb_mispred,
    input  logic [N_WB_PORTS-1:0][XLEN-1:0]      wb_npc,

    output logic [RETIRE_WIDTH-1:0]              retire_valid,
    output logic [RETIRE_WIDTH-1:0]              retire_arf_we,
    output logic [RETIRE_WIDTH-1:0][ARF_ID_W-1:0] retire_arf_id,
    output logic [RETIRE_WIDTH-1:0][XLEN-1:0]    retire_reg_data,
    output logic [RETIRE_WIDTH-1:0][ID_W-1:0]    retire_rob_id,

    output logic                                 redirect_valid,
    output logic [XLEN-1:0]                      redirect_pc
);

    localparam int unsigned PTR_W = ID_W + 1;
    localparam int unsigned CNT_W = cnt_width(RETIRE_WIDTH);

    rob_entry_t             ent_q [N_ENTRIES];
    rob_entry_t             ent_d [N_ENTRIES];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic                   full;

    logic [RETIRE_WIDTH-1:0]           win_valid;
    logic [RETIRE_WIDTH-1:0]           win_exec;
    logic [RETIRE_WIDTH-1:0]           win_mis;
    logic [RETIRE_WIDTH-1:0][ID_W-1:0] win_idx;
    logic [CNT_W-1:0]                  retire_cnt;
    logic                              flush;

    assign full = (head_q[ID_W] != tail_q[ID_W]) && (head_q[ID_W-1:0] == tail_q[ID_W-1:0]);

    assign redirect_valid  = flush;
    assign dispatch_ready  = !full && !flush;
    assign dispatch_rob_id = tail_q[ID_W-1:0];

    always_comb begin
        win_idx   = '0;
        win_valid = '0;
        win_exec  = '0;
        win_mis   = '0;
        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            win_idx[k]   = head_q[ID_W-1:0] + ID_W'(k);
            win_valid[k] = ent_q[win_idx[k]].valid;
            win_exec[k]  = ent_q[win_idx[k]].is_executed;
            win_mis[k]   = ent_q[win_idx[k]].br_mispred;
        end
    end

    rob_retire_select #(
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .CNT_W        (CNT_W)
    ) u_retire_select (
        .valid_i      (win_valid),
        .executed_i   (win_exec),
        .mispred_i    (win_mis),
        .retire_o     (retire_valid),
        .retire_cnt_o (retire_cnt),
        .flush_o      (flush)
    );

    always_comb begin
        retire_arf_we   = '0;
        retire_arf_id   = '0;
        retire_reg_data = '0;
        retire_rob_id   = '0;
        redirect_pc     = '0;
        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            if (retire_valid[k]) begin
                retire_arf_we[k]   = ent_q[win_idx[k]].dst_valid && !win_mis[k];
                retire_arf_id[k]   = ent_q[win_idx[k]].dst_arf_id;
                retire_reg_data[k] = ent_q[win_idx[k]].reg_data;
                retire_rob_id[k]   = win_idx[k];
                if (win_mis[k]) begin
                    redirect_pc = ent_q[win_idx[k]].pc_npc;
                end
            end
        end
    end

    // Ascending port loop so the highest matching writeback port wins the bypass.
    always_comb begin
        rd_ready = '0;
        rd_data  = '0;
        for (int r = 0; r < int'(N_RD_PORTS); r++) begin
            rd_ready[r] = ent_q[rd_rob_id[r]].valid && ent_q[rd_rob_id[r]].is_executed;
            rd_data[r]  = ent_q[rd_rob_id[r]].reg_data;
            for (int p = 0; p < int'(N_WB_PORTS); p++) begin
                if (wb_valid[p] && (wb_rob_id[p] == rd_rob_id[r])) begin
                    rd_ready[r] = 1'b1;
                    rd_data[r]  = wb_reg_data[p];
                end
            end
        end
    end

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q + PTR_W'(retire_cnt);
        tail_d = tail_q;

        if (dispatch_valid && dispatch_ready) begin
            ent_d[tail_q[ID_W-1:0]].valid       = 1'b1;
            ent_d[tail_q[ID_W-1:0]].dst_valid   = dispatch_data.dst_valid;
            ent_d[tail_q[ID_W-1:0]].dst_arf_id  = dispatch_data.dst_arf_id;
            ent_d[tail_q[ID_W-1:0]].pc_npc      = dispatch_data.pc;
            ent_d[tail_q[ID_W-1:0]].br_mispred  = 1'b0;
            ent_d[tail_q[ID_W-1:0]].is_executed = 1'b0;
            ent_d[tail_q[ID_W-1:0]].reg_data    = '0;
            tail_d = tail_q + PTR_W'(1);
        end

        // Validity is judged on the registered entry, so a write to the slot being
        // dispatched this cycle is dropped.
        for (int p = 0; p < int'(N_WB_PORTS); p++) begin
            if (wb_valid[p] && ent_q[wb_rob_id[p]].valid) begin
                ent_d[wb_rob_id[p]].is_executed = 1'b1;
                ent_d[wb_rob_id[p]].reg_data    = wb_reg_data[p];
                if (wb_npc_valid[p]) begin
                    ent_d[wb_rob_id[p]].pc_npc     = wb_npc[p];
                    ent_d[wb_rob_id[p]].br_mispred = wb_mispred[p];
                end
            end
        end

        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            if (retire_valid[k]) begin
                ent_d[win_idx[k]].valid = 1'b0;
            end
        end

        if (flush) begin
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Randomized bench for rob_multi against a program-order queue model of the ROB.
module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int N   = 16;
    localparam int WB  = 3;
    localparam int RW  = 2;
    localparam int RD  = 2;
    localparam int IDW = 4;

    logic                       clk = 1'b0;
    logic                       rst_aL;
    logic                       dispatch_valid;
    logic                       dispatch_ready;
    logic [IDW-1:0]             dispatch_rob_id;
    rob_dispatch_data_t         dispatch_data;
    logic [RD-1:0][IDW-1:0]     rd_rob_id;
    logic [RD-1:0]              rd_ready;
    logic [RD-1:0][31:0]        rd_data;
    logic [WB-1:0]              wb_valid;
    logic [WB-1:0][IDW-1:0]     wb_rob_id;
    logic [WB-1:0][31:0]        wb_reg_data;
    logic [WB-1:0]              wb_npc_valid;
    logic [WB-1:0]              wb_mispred;
    logic [WB-1:0][31:0]        wb_npc;
    logic [RW-1:0]              retire_valid;
    logic [RW-1:0]              retire_arf_we;
    logic [RW-1:0][4:0]         retire_arf_id;
    logic [RW-1:0][31:0]        retire_reg_data;
    logic [RW-1:0][IDW-1:0]     retire_rob_id;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;

    always #5 clk = ~clk;

    rob_multi #(
        .N_ENTRIES    (N),
        .N_WB_PORTS   (WB),
        .RETIRE_WIDTH (RW),
        .N_RD_PORTS   (RD)
    ) dut (
        .clk             (clk),
        .rst_aL          (rst_aL),
        .dispatch_valid  (dispatch_valid),
        .dispatch_ready  (dispatch_ready),
        .dispatch_rob_id (dispatch_rob_id),
        .dispatch_data   (dispatch_data),
        .rd_rob_id       (rd_rob_id),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .wb_valid        (wb_valid),
        .wb_rob_id       (wb_rob_id),
        .wb_reg_data     (wb_reg_data),
        .wb_npc_valid    (wb_npc_valid),
        .wb_mispred      (wb_mispred),
        .wb_npc          (wb_npc),
        .retire_valid    (retire_valid),
        .retire_arf_we   (retire_arf_we),
        .retire_arf_id   (retire_arf_id),
        .retire_reg_data (retire_reg_data),
        .retire_rob_id   (retire_rob_id),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-flight ids in program order plus per-id attributes.
    int          q[$];
    bit          m_valid [N];
    bit          m_dst   [N];
    bit [4:0]    m_arf   [N];
    bit [31:0]   m_npc   [N];
    bit          m_mis   [N];
    bit          m_exec  [N];
    bit [31:0]   m_data  [N];
    int          next_id;

    task automatic model_reset();
        q.delete();
        next_id = 0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_dst[i] = 0; m_arf[i] = '0; m_npc[i] = '0;
            m_mis[i] = 0; m_exec[i] = 0; m_data[i] = '0;
        end
    endtask

    task automatic drive_idle();
        dispatch_valid = 1'b0;
        dispatch_data  = '0;
        rd_rob_id      = '0;
        wb_valid       = '0;
        wb_rob_id      = '0;
        wb_reg_data    = '0;
        wb_npc_valid   = '0;
        wb_mispred     = '0;
        wb_npc         = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".dispatch_ready"}, 64'(dispatch_ready), 64'd1);
        check_eq({tag, ".dispatch_rob_id"}, 64'(dispatch_rob_id), 64'd0);
        check_eq({tag, ".retire_valid"}, 64'(retire_valid), 64'd0);
        check_eq({tag, ".retire_arf_we"}, 64'(retire_arf_we), 64'd0);
        check_eq({tag, ".retire_rob_id"}, 64'(retire_rob_id), 64'd0);
        check_eq({tag, ".redirect_valid"}, 64'(redirect_valid), 64'd0);
        check_eq({tag, ".redirect_pc"}, 64'(redirect_pc), 64'd0);
        check_eq({tag, ".rd_ready"}, 64'(rd_ready), 64'd0);
    endtask

    task automatic drive_random(input int dv_pct, input int wb_pct, input int mis_pct);
        int same;
        int shared_id;
        dispatch_valid           = ($urandom_range(0, 99) < dv_pct);
        dispatch_data.dst_valid  = 1'($urandom);
        dispatch_data.dst_arf_id = 5'($urandom);
        dispatch_data.pc         = $urandom;
        same      = ($urandom_range(0, 3) == 0);
        shared_id = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, N - 1));
        for (int p = 0; p < WB; p++) begin
            wb_valid[p] = ($urandom_range(0, 99) < wb_pct);
            if (same) wb_rob_id[p] = IDW'(shared_id);
            else if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wb_rob_id[p] = IDW'(q[$urandom_range(0, q.size() - 1)]);
            else wb_rob_id[p] = IDW'($urandom);
            wb_reg_data[p]  = $urandom;
            wb_npc_valid[p] = ($urandom_range(0, 2) == 0);
            wb_mispred[p]   = ($urandom_range(0, 99) < mis_pct);
            wb_npc[p]       = $urandom;
        end
        for (int r = 0; r < RD; r++) begin
            if ($urandom_range(0, 1) == 0) rd_rob_id[r] = wb_rob_id[$urandom_range(0, WB - 1)];
            else rd_rob_id[r] = IDW'($urandom);
        end
    endtask

    // Compare DUT outputs with the model for the inputs now applied, then advance
    // the model to the state after the coming rising edge.
    task automatic check_and_step();
        bit [RW-1:0] exp_rv;
        int          nret;
        bit          redir;
        bit [31:0]   rpc;
        bit          exp_ready;
        bit          pre_valid [N];
        int          e;
        int          id;
        bit          rdy;
        bit [31:0]   d;

        exp_rv = '0; nret = 0; redir = 0; rpc = '0;
        for (int k = 0; k < RW; k++) begin
            if (redir || k >= q.size() || !m_exec[q[k]]) break;
            exp_rv[k] = 1'b1;
            nret++;
            if (m_mis[q[k]]) begin
                redir = 1;
                rpc   = m_npc[q[k]];
            end
        end
        exp_ready = (q.size() < N) && !redir;

        check_eq("dispatch_ready", 64'(dispatch_ready), 64'(exp_ready));
        check_eq("dispatch_rob_id", 64'(dispatch_rob_id), 64'(next_id));
        check_eq("retire_valid", 64'(retire_valid), 64'(exp_rv));
        check_eq("redirect_valid", 64'(redirect_valid), 64'(redir));
        if (redir) check_eq("redirect_pc", 64'(redirect_pc), 64'(rpc));
        for (int k = 0; k < nret; k++) begin
            e = q[k];
            check_eq($sformatf("retire_rob_id[%0d]", k), 64'(retire_rob_id[k]), 64'(e));
            check_eq($sformatf("retire_arf_we[%0d]", k), 64'(retire_arf_we[k]),
                     64'(m_dst[e] && !m_mis[e]));
            check_eq($sformatf("retire_arf_id[%0d]", k), 64'(retire_arf_id[k]), 64'(m_arf[e]));
            check_eq($sformatf("retire_reg_data[%0d]", k), 64'(retire_reg_data[k]), 64'(m_data[e]));
        end
        for (int r = 0; r < RD; r++) begin
            id  = int'(rd_rob_id[r]);
            rdy = m_valid[id] && m_exec[id];
            d   = m_data[id];
            for (int p = 0; p < WB; p++) begin
                if (wb_valid[p] && int'(wb_rob_id[p]) == id) begin
                    rdy = 1;
                    d   = wb_reg_data[p];
                end
            end
            check_eq($sformatf("rd_ready[%0d]", r), 64'(rd_ready[r]), 64'(rdy));
            if (rdy) check_eq($sformatf("rd_data[%0d]", r), 64'(rd_data[r]), 64'(d));
        end

        for (int i = 0; i < N; i++) pre_valid[i] = m_valid[i];
        for (int p = 0; p < WB; p++) begin
            id = int'(wb_rob_id[p]);
            if (wb_valid[p] && pre_valid[id]) begin
                m_exec[id] = 1;
                m_data[id] = wb_reg_data[p];
                if (wb_npc_valid[p]) begin
                    m_npc[id] = wb_npc[p];
                    m_mis[id] = wb_mispred[p];
                end
            end
        end
        for (int k = 0; k < nret; k++) begin
            m_valid[q[0]] = 0;
            void'(q.pop_front());
        end
        if (redir) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            q.delete();
            next_id = 0;
        end else if (dispatch_valid && exp_ready) begin
            m_valid[next_id] = 1;
            m_dst[next_id]   = dispatch_data.dst_valid;
            m_arf[next_id]   = dispatch_data.dst_arf_id;
            m_npc[next_id]   = dispatch_data.pc;
            m_mis[next_id]   = 0;
            m_exec[next_id]  = 0;
            q.push_back(next_id);
            next_id = (next_id + 1) % N;
        end
    endtask

    task automatic run_cycles(input int n, input int dv_pct, input int wb_pct, input int mis_pct);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drive_random(dv_pct, wb_pct, mis_pct);
            #1;
            check_and_step();
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        rst_aL = 1'b1;
        #1 rst_aL = 1'b0;
        #20;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_aL = 1'b1;

        // Fill with no writebacks: dispatch_ready must drop once 16 are in flight.
        run_cycles(20, 100, 0, 0);
        // Drain and mix.
        run_cycles(40, 0, 80, 0);
        run_cycles(1500, 60, 50, 5);
        run_cycles(300, 90, 20, 2);

        // Asynchronous reset mid-operation, checked before any clock edge.
        @(posedge clk);
        #2;
        rst_aL = 1'b0;
        drive_idle();
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_aL = 1'b1;

        run_cycles(1000, 60, 50, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
